// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: LSB-first bit collection into a registered valid/ready word.
// Optional PARITY_CHECK_EN adds a trailing even-parity bit per frame and a parity_err sideband.
module sipo_deser #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             parity_err,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [0:0] {COLLECT = 1'b0, PARITY = 1'b1} state_t;
`else
  typedef enum logic [0:0] {COLLECT = 1'b0} state_t;
`endif

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] new_word;
  logic             shift_en;
  logic             word_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      COLLECT: begin
        if (sin_en) begin
          if (cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            next_state = PARITY;
            next_cnt   = cnt + CNT_W'(1);
`else
            next_cnt   = '0;
`endif
          end else begin
            next_cnt = cnt + CNT_W'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (sin_en) begin
          next_state = COLLECT;
          next_cnt   = '0;
        end
      end
`endif
      default: begin
        next_state = COLLECT;
        next_cnt   = '0;
      end
    endcase
  end

  // Output logic: data bits shift only in COLLECT; the frame ends on its last strobe
  always_comb begin
    shift_en  = sin_en && (state == COLLECT);
`ifdef PARITY_CHECK_EN
    word_done = sin_en && (state == PARITY);
`else
    word_done = sin_en && (state == COLLECT) && (cnt == LAST_BIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (shift_en) begin
      sreg <= {sin, sreg[WIDTH-1:1]};
    end
  end

`ifdef PARITY_CHECK_EN
  // The parity bit is not shifted in, so sreg already holds the full word
  assign new_word = sreg;
`else
  assign new_word = {sin, sreg[WIDTH-1:1]};
`endif

  // Output register: a completing word loads unless an unaccepted word is still held
  always_ff @(posedge clk) begin
    if (reset) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (!pout_valid || pout_ready) begin
        pout       <= new_word;
        pout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (pout_valid && pout_ready) begin
      pout_valid <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (word_done && (!pout_valid || pout_ready)) begin
      perr_q <= ^{sreg, sin};
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser (WIDTH=4): gapless, gapped, simultaneous accept,
// overrun, mid-word reset and, with PARITY_CHECK_EN, parity checking.
module tb_sipo_deser;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             sin;
  logic             sin_en;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             parity_err;
  logic             overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_deser #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .sin_en     (sin_en),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change #1 after the rising edge, outputs are checked there too
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    sin        = b;
    sin_en     = 1'b1;
    pout_ready = rdy;
    @(posedge clk);
    #1;
    sin_en     = 1'b0;
    pout_ready = 1'b0;
  endtask

  // Sends the frame tail: nothing by default, the even-parity bit with the feature
  task automatic send_tail(input logic [WIDTH-1:0] w, input logic rdy);
`ifdef PARITY_CHECK_EN
    send_bit(^w, rdy);
`else
    if (rdy) pout_ready = 1'b0;
    if (w === 'x) $display("send_tail: unknown word");
`endif
  endtask

  // Whole frame, LSB first; rdy_last raises pout_ready only on the completing edge
  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
`ifdef PARITY_CHECK_EN
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], 1'b0);
    send_tail(w, rdy_last);
`else
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], rdy_last && (i == WIDTH - 1));
`endif
  endtask

  task automatic accept();
    pout_ready = 1'b1;
    @(posedge clk);
    #1;
    pout_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  logic [WIDTH-1:0] vec_d;
  int               gaps [3];

  initial begin
    sin        = 1'b0;
    sin_en     = 1'b0;
    pout_ready = 1'b0;
    reset      = 1'b0;
    vec_d      = 4'b1101;
    gaps       = '{2, 0, 3};
    #1;

    // 1. reset state and gapless word
    do_reset(2);
    check("rst_pout", 32'(pout), 32'h0);
    check("rst_valid", 32'(pout_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    for (int i = 0; i < WIDTH - 1; i++) send_bit(vec_d[i], 1'b0);
    check("t1_valid_early", 32'(pout_valid), 32'h0);
    send_bit(vec_d[WIDTH-1], 1'b0);
    send_tail(vec_d, 1'b0);
    check("t1_pout", 32'(pout), 32'hD);
    check("t1_valid", 32'(pout_valid), 32'h1);
    check("t1_perr", 32'(parity_err), 32'h0);
    accept();
    check("t1_valid_clr", 32'(pout_valid), 32'h0);
    check("t1_pout_hold", 32'(pout), 32'hD);

    // 2. gapped stream
    for (int i = 0; i < WIDTH - 1; i++) begin
      send_bit(vec_d[i], 1'b0);
      idle(gaps[i]);
      check("t2_valid_early", 32'(pout_valid), 32'h0);
    end
    send_bit(vec_d[WIDTH-1], 1'b0);
    send_tail(vec_d, 1'b0);
    check("t2_pout", 32'(pout), 32'hD);
    check("t2_valid", 32'(pout_valid), 32'h1);
    accept();

    // 3. back-to-back A then 5, accepted on the completion edge of 5
    send_word(4'hA, 1'b0);
    check("t3_pout_a", 32'(pout), 32'hA);
    check("t3_valid_a", 32'(pout_valid), 32'h1);
    send_word(4'h5, 1'b1);
    check("t3_pout_5", 32'(pout), 32'h5);
    check("t3_valid_5", 32'(pout_valid), 32'h1);
    check("t3_overrun", 32'(overrun), 32'h0);
    accept();
    check("t3_valid_clr", 32'(pout_valid), 32'h0);

    // 4. overrun: 3 held, C dropped
    send_word(4'h3, 1'b0);
    check("t4_pout_3", 32'(pout), 32'h3);
    check("t4_overrun_pre", 32'(overrun), 32'h0);
    send_word(4'hC, 1'b0);
    check("t4_pout_keep", 32'(pout), 32'h3);
    check("t4_valid", 32'(pout_valid), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h1);
    accept();
    check("t4_valid_clr", 32'(pout_valid), 32'h0);
    idle(2);
    check("t4_overrun_sticky", 32'(overrun), 32'h1);

    // 5. reset mid-word discards the partial word
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    do_reset(1);
    check("t5_overrun_clr", 32'(overrun), 32'h0);
    check("t5_pout_clr", 32'(pout), 32'h0);
    vec_d = 4'b0110;
    for (int i = 0; i < WIDTH - 1; i++) begin
      send_bit(vec_d[i], 1'b0);
      check("t5_valid_early", 32'(pout_valid), 32'h0);
    end
    send_bit(vec_d[WIDTH-1], 1'b0);
    send_tail(vec_d, 1'b0);
    check("t5_pout", 32'(pout), 32'h6);
    check("t5_valid", 32'(pout_valid), 32'h1);
    accept();

`ifdef PARITY_CHECK_EN
    // 6. parity good then bad
    vec_d = 4'b1101;
    for (int i = 0; i < WIDTH; i++) send_bit(vec_d[i], 1'b0);
    check("t6_valid_before_par", 32'(pout_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    check("t6_pout", 32'(pout), 32'hD);
    check("t6_perr_ok", 32'(parity_err), 32'h0);
    accept();
    for (int i = 0; i < WIDTH; i++) send_bit(vec_d[i], 1'b0);
    send_bit(1'b0, 1'b0);
    check("t6_pout_bad", 32'(pout), 32'hD);
    check("t6_perr_bad", 32'(parity_err), 32'h1);
    accept();
`else
    check("t6_perr_absent", 32'(parity_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
